// File: rtl/josh_game_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : josh_game_sequencer
// Purpose  : Top-level game sequencer. Runs the menu / start-on-release flow,
//            then paces one physics step and one redraw per frame tick, and
//            holds a game-over screen for OVER_FRAMES ticks before returning
//            to the menu.
// Ports    : clk, resetn (async, active-low)
//            go        - start key level
//            grav_sw   - gravity switch level, sampled on the frame tick
//            endgame   - collision result, valid with step_done
//            step_done - physics step finished
//            draw_done - redraw finished
//            startgame - game in progress (INIT/WAIT_TICK/STEP/DRAW)
//            clear_req - one-cycle datapath reinitialise pulse
//            step_req  - physics step request level
//            draw_req  - redraw request level
//            grav      - gravity latched for the current frame
//            score     - completed frames in this game (saturating at 255)
//            overrun   - sticky, a frame tick arrived while still busy
//            state_dbg - current state code
// Config   : JOSH_SEQ_SCORE_EN - when defined, the score register is built;
//            otherwise score is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module josh_game_sequencer #(
  parameter int FRAME_DIV   = 833333,
  parameter int OVER_FRAMES = 120
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       go,
  input  logic       grav_sw,
  input  logic       endgame,
  input  logic       step_done,
  input  logic       draw_done,
  output logic       startgame,
  output logic       clear_req,
  output logic       step_req,
  output logic       draw_req,
  output logic       grav,
  output logic [7:0] score,
  output logic       overrun,
  output logic [2:0] state_dbg
);

  localparam int                 c_cnt_w      = $clog2(FRAME_DIV);
  localparam logic [c_cnt_w-1:0] c_frame_last = c_cnt_w'(FRAME_DIV - 1);
  localparam logic [7:0]         c_over_last  = 8'(OVER_FRAMES - 1);

  typedef enum logic [2:0] {
    S_MENU      = 3'd0,
    S_MENU_WAIT = 3'd1,
    S_INIT      = 3'd2,
    S_WAIT_TICK = 3'd3,
    S_STEP      = 3'd4,
    S_DRAW      = 3'd5,
    S_OVER      = 3'd6
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [c_cnt_w-1:0] r_frame_cnt;
  logic [7:0]         r_over_cnt;
  logic               w_tick;
  logic               w_busy;
  logic               r_startgame;
  logic               r_clear_req;
  logic               r_step_req;
  logic               r_draw_req;
  logic               r_grav;
  logic               r_overrun;

  // Free-running frame divider; independent of the game state.
  assign w_tick = (r_frame_cnt == c_frame_last);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_frame_cnt <= '0;
    end else if (w_tick) begin
      r_frame_cnt <= '0;
    end else begin
      r_frame_cnt <= r_frame_cnt + c_cnt_w'(1);
    end
  end

  assign w_busy = (r_state == S_STEP) || (r_state == S_DRAW);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_MENU:      if (go) w_next = S_MENU_WAIT;
      S_MENU_WAIT: if (!go) w_next = S_INIT;
      S_INIT:      w_next = S_WAIT_TICK;
      S_WAIT_TICK: if (w_tick) w_next = S_STEP;
      S_STEP:      if (step_done) w_next = endgame ? S_OVER : S_DRAW;
      S_DRAW:      if (draw_done) w_next = S_WAIT_TICK;
      S_OVER:      if (w_tick && (r_over_cnt == c_over_last)) w_next = S_MENU;
      default:     w_next = S_MENU;
    endcase
  end

  // Request outputs are registered from the next state so they line up
  // exactly with the state register and never see an input combinationally.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_MENU;
      r_over_cnt  <= 8'd0;
      r_startgame <= 1'b0;
      r_clear_req <= 1'b0;
      r_step_req  <= 1'b0;
      r_draw_req  <= 1'b0;
      r_grav      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_clear_req <= (w_next == S_INIT);
      r_step_req  <= (w_next == S_STEP);
      r_draw_req  <= (w_next == S_DRAW);
      r_startgame <= (w_next inside {S_INIT, S_WAIT_TICK, S_STEP, S_DRAW});

      if ((r_state == S_WAIT_TICK) && w_tick) begin
        r_grav <= grav_sw;
      end

      // A tick while busy is lost; remember that it happened.
      if (w_next == S_INIT) begin
        r_overrun <= 1'b0;
      end else if (w_busy && w_tick) begin
        r_overrun <= 1'b1;
      end

      if (r_state != S_OVER) begin
        r_over_cnt <= 8'd0;
      end else if (w_tick) begin
        r_over_cnt <= r_over_cnt + 8'd1;
      end
    end
  end

`ifdef JOSH_SEQ_SCORE_EN
  logic [7:0] r_score;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_score <= 8'd0;
    end else if (w_next == S_INIT) begin
      r_score <= 8'd0;
    end else if ((r_state == S_DRAW) && draw_done && (r_score != 8'hFF)) begin
      r_score <= r_score + 8'd1;
    end
  end

  assign score = r_score;
`else
  assign score = 8'd0;
`endif

  assign startgame = r_startgame;
  assign clear_req = r_clear_req;
  assign step_req  = r_step_req;
  assign draw_req  = r_draw_req;
  assign grav      = r_grav;
  assign overrun   = r_overrun;
  assign state_dbg = r_state;

endmodule
`default_nettype wire

// File: tb/tb_josh_game_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_josh_game_sequencer
// Purpose  : Self-checking bench for josh_game_sequencer with FRAME_DIV=4,
//            OVER_FRAMES=2. Expected outputs come from a frame-level model:
//            tick timing from the edge count since reset, and score, grav
//            and overrun from the game rules applied per frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_josh_game_sequencer;

  localparam int FRAME_DIV   = 4;
  localparam int OVER_FRAMES = 2;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       go = 1'b0, grav_sw = 1'b0, endgame = 1'b0;
  logic       step_done = 1'b0, draw_done = 1'b0;
  logic       startgame, clear_req, step_req, draw_req, grav, overrun;
  logic [7:0] score;
  logic [2:0] state_dbg;

  int   checks = 0;
  int   errors = 0;
  int   edges = 0;
  int   exp_score = 0;
  logic exp_grav = 1'b0;
  logic exp_ov = 1'b0;

  logic [16:0] obs;
  assign obs = {state_dbg, startgame, clear_req, step_req, draw_req, grav, overrun, score};

  josh_game_sequencer #(.FRAME_DIV(FRAME_DIV), .OVER_FRAMES(OVER_FRAMES)) dut (
    .clk(clk), .resetn(resetn), .go(go), .grav_sw(grav_sw), .endgame(endgame),
    .step_done(step_done), .draw_done(draw_done), .startgame(startgame),
    .clear_req(clear_req), .step_req(step_req), .draw_req(draw_req), .grav(grav),
    .score(score), .overrun(overrun), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Edges since reset release; the frame tick is the last count of each frame.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) edges <= 0;
    else         edges <= edges + 1;
  end

  function automatic bit tick_now();
    return (edges % FRAME_DIV) == (FRAME_DIV - 1);
  endfunction

  // Moore outputs implied by a state: {state, startgame, clear, step, draw}.
  function automatic logic [6:0] moore(input int s);
    return {3'(s), (s >= 2 && s <= 5), (s == 2), (s == 4), (s == 5)};
  endfunction

  function automatic logic [7:0] exp_sc();
`ifdef JOSH_SEQ_SCORE_EN
    return 8'(exp_score);
`else
    return 8'd0;
`endif
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (obs !== 17'd0) begin
      errors++; $display("FAIL reset_async: got %h want %h", obs, 17'd0);
    end
    cyc(); cyc();
    checks++;
    if (obs !== 17'd0) begin
      errors++; $display("FAIL reset_held: got %h want %h", obs, 17'd0);
    end
    resetn = 1'b1;
    exp_score = 0; exp_grav = 1'b0; exp_ov = 1'b0;
  endtask

  task automatic test_start(input int go_cycles);
    checks++;
    if (obs !== {moore(0), exp_grav, exp_ov, exp_sc()}) begin
      errors++; $display("FAIL start_menu: got %h want %h", obs, {moore(0), exp_grav, exp_ov, exp_sc()});
    end
    go = 1'b1;
    for (int i = 0; i < go_cycles; i++) begin
      cyc();
      checks++;
      if (obs !== {moore(1), exp_grav, exp_ov, exp_sc()}) begin
        errors++; $display("FAIL start_menu_wait: got %h want %h", obs, {moore(1), exp_grav, exp_ov, exp_sc()});
      end
    end
    go = 1'b0;
    cyc();
    checks++;
    if ({obs[16:10], obs[9]} !== {moore(2), exp_grav}) begin
      errors++; $display("FAIL start_init: got %h want %h", {obs[16:10], obs[9]}, {moore(2), exp_grav});
    end
    exp_score = 0; exp_ov = 1'b0;
    cyc();
  endtask

  // One frame: wait for the tick, step with latency sl, then (unless eg)
  // redraw with latency dl. Leaves the bench at the negedge after the frame.
  task automatic play_frame(input int sl, input int dl, input bit eg, input bit tog);
    int n = 0;
    while (1) begin
      checks++;
      if (obs !== {moore(3), exp_grav, exp_ov, exp_sc()}) begin
        errors++; $display("FAIL frame_wait: got %h want %h", obs, {moore(3), exp_grav, exp_ov, exp_sc()});
      end
      grav_sw = 1'($urandom); step_done = 1'($urandom); draw_done = 1'($urandom);
      if (tick_now()) break;
      cyc(); n++;
      if (n > 2 * FRAME_DIV) begin
        checks++; errors++;
        $display("FAIL frame_wait_timeout: got state %0d want tick within %0d cycles", state_dbg, 2 * FRAME_DIV);
        return;
      end
    end
    exp_grav = grav_sw;
    cyc();
    for (int i = 0; i <= sl; i++) begin
      checks++;
      if (obs !== {moore(4), exp_grav, exp_ov, exp_sc()}) begin
        errors++; $display("FAIL frame_step: got %h want %h", obs, {moore(4), exp_grav, exp_ov, exp_sc()});
      end
      step_done = (i == sl); endgame = eg; draw_done = 1'($urandom);
      if (tog) grav_sw = ~grav_sw;
      if (tick_now()) exp_ov = 1'b1;
      cyc();
    end
    step_done = 1'b0; endgame = 1'b0;
    if (eg) return;
    for (int i = 0; i <= dl; i++) begin
      checks++;
      if (obs !== {moore(5), exp_grav, exp_ov, exp_sc()}) begin
        errors++; $display("FAIL frame_draw: got %h want %h", obs, {moore(5), exp_grav, exp_ov, exp_sc()});
      end
      draw_done = (i == dl); step_done = 1'($urandom);
      if (tick_now()) exp_ov = 1'b1;
      if (i == dl && exp_score < 255) exp_score++;
      cyc();
    end
    draw_done = 1'b0; step_done = 1'b0;
  endtask

  task automatic test_over();
    int t = 0;
    int n = 0;
    while (t < OVER_FRAMES) begin
      checks++;
      if (obs !== {moore(6), exp_grav, exp_ov, exp_sc()}) begin
        errors++; $display("FAIL over_hold: got %h want %h", obs, {moore(6), exp_grav, exp_ov, exp_sc()});
      end
      go = 1'($urandom); step_done = 1'($urandom); draw_done = 1'($urandom); endgame = 1'($urandom);
      if (tick_now()) t++;
      cyc(); n++;
      if (n > OVER_FRAMES * FRAME_DIV + 4) begin
        checks++; errors++;
        $display("FAIL over_timeout: got state %0d want MENU within %0d cycles", state_dbg, n);
        break;
      end
    end
    go = 1'b0; step_done = 1'b0; draw_done = 1'b0; endgame = 1'b0;
    checks++;
    if (obs !== {moore(0), exp_grav, exp_ov, exp_sc()}) begin
      errors++; $display("FAIL over_to_menu: got %h want %h", obs, {moore(0), exp_grav, exp_ov, exp_sc()});
    end
  endtask

  task automatic test_frames();
    for (int f = 0; f < 3; f++) play_frame(0, 0, 1'b0, 1'b0);
    checks++;
    if ({overrun, score} !== {1'b0, exp_sc()}) begin
      errors++; $display("FAIL frames_three: got ov=%b score=%0d want ov=0 score=%0d", overrun, score, exp_sc());
    end
  endtask

  task automatic test_overrun();
    play_frame(6, 0, 1'b1, 1'b0);
    checks++;
    if ({overrun, startgame, state_dbg} !== {1'b1, 1'b0, 3'd6}) begin
      errors++; $display("FAIL overrun_stall: got ov=%b sg=%b st=%0d want ov=1 sg=0 st=6", overrun, startgame, state_dbg);
    end
    test_over();
  endtask

  task automatic test_grav();
    test_start(1);
    for (int f = 0; f < 4; f++) play_frame($urandom_range(0, 1), 0, 1'b0, 1'b1);
    play_frame(0, 0, 1'b1, 1'b1);
    test_over();
  endtask

  task automatic test_saturate();
    test_start(2);
    for (int f = 0; f < 260; f++) play_frame(0, 0, 1'b0, 1'b0);
    play_frame(0, 0, 1'b1, 1'b0);
    test_over();
  endtask

  task automatic test_random();
    for (int g = 0; g < 5; g++) begin
      int nf = 0;
      bit eg;
      test_start($urandom_range(1, 3));
      do begin
        eg = (nf >= 6) || ($urandom_range(0, 4) == 0);
        play_frame($urandom_range(0, 3), $urandom_range(0, 3), eg, 1'($urandom));
        nf++;
      end while (!eg);
      test_over();
    end
  endtask

  task automatic test_reset_mid_draw();
    int n = 0;
    test_start(1);
    while (!tick_now() && n < 2 * FRAME_DIV) begin
      cyc(); n++;
    end
    cyc();
    step_done = 1'b1; endgame = 1'b0;
    cyc();
    step_done = 1'b0;
    checks++;
    if ({state_dbg, draw_req} !== {3'd5, 1'b1}) begin
      errors++; $display("FAIL middraw_enter: got st=%0d dr=%b want st=5 dr=1", state_dbg, draw_req);
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({draw_req, state_dbg, score} !== 12'd0) begin
      errors++; $display("FAIL middraw_reset: got dr=%b st=%0d score=%0d want 0 0 0", draw_req, state_dbg, score);
    end
    @(negedge clk);
    resetn = 1'b1;
    exp_score = 0; exp_grav = 1'b0; exp_ov = 1'b0;
    cyc();
    checks++;
    if (obs !== {moore(0), 1'b0, 1'b0, 8'd0}) begin
      errors++; $display("FAIL middraw_after: got %h want %h", obs, {moore(0), 1'b0, 1'b0, 8'd0});
    end
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_start(3);
    test_frames();
    test_overrun();
    test_grav();
    test_random();
    test_saturate();
    test_reset_mid_draw();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/josh_game_sequencer.md
JOSH_GAME_SEQUENCER -- requirements
Module: josh_game_sequencer

Interface
REQ-001: Parameter FRAME_DIV, default 833333; clk cycles per frame tick (60 Hz at 50 MHz); legal range 4..2^20.
REQ-002: Parameter OVER_FRAMES, default 120; frame ticks spent in game-over before returning to menu; legal range 1..255.
REQ-003: The block SHALL provide these ports:
- clk  in  1  system clock; all state changes on the rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- go  in  1  level; user start request (inverted key).
- grav_sw  in  1  gravity switch level; 0 = down, 1 = up.
- endgame  in  1  collision result from datapath; valid in the cycle step_done=1.
- step_done  in  1  datapath has finished the physics step.
- draw_done  in  1  screen updater has finished redrawing.
- startgame  out  1  1 while a game is in progress.
- clear_req  out  1  one-cycle pulse; datapath reinitialises walls and dude.
- step_req  out  1  level request for one physics step.
- draw_req  out  1  level request for one screen redraw.
- grav  out  1  gravity value latched for the current frame.
- score  out  8  number of completed frames in the current game.
- overrun  out  1  sticky flag; a frame tick was missed.
- state_dbg  out  3  current state encoding.

Function
REQ-004: State encoding SHALL be MENU=0, MENU_WAIT=1, INIT=2, WAIT_TICK=3, STEP=4, DRAW=5, OVER=6; code 7 SHALL go to MENU on the next cycle.
REQ-005: Frame counter SHALL run free from reset, counting 0..FRAME_DIV-1 and wrapping; tick=1 for the single cycle in which the count equals FRAME_DIV-1.
REQ-006: MENU: go=1 goes to MENU_WAIT; otherwise hold.
REQ-007: MENU_WAIT: hold while go=1; go=0 goes to INIT, so a game starts on key release.
REQ-008: INIT SHALL last exactly one cycle, with clear_req=1, score cleared to 0 and overrun cleared to 0; it SHALL then go to WAIT_TICK.
REQ-009: WAIT_TICK: tick=1 goes to STEP, and grav is loaded with grav_sw on that same edge; otherwise hold.
REQ-010: STEP SHALL hold step_req=1 until step_done=1. In that cycle, endgame=1 goes to OVER and endgame=0 goes to DRAW.
REQ-011: DRAW SHALL hold draw_req=1 until draw_done=1. On that edge the state goes to WAIT_TICK and score increments, saturating at 255.
REQ-012: A tick occurring in STEP or DRAW SHALL be dropped, not queued, and SHALL set overrun=1.
REQ-013: OVER SHALL count ticks. It goes to MENU on the edge where the OVER_FRAMES-th tick is seen, and go is ignored while in OVER.
REQ-014: startgame SHALL be 1 exactly in INIT, WAIT_TICK, STEP and DRAW.
REQ-015: step_req, draw_req and clear_req are Moore outputs of the state register, with no combinational path from any input.
REQ-016: step_done and draw_done SHALL be ignored outside STEP and DRAW respectively.
REQ-017: If step_done and tick coincide in STEP, the step is accepted and overrun is set.
REQ-018: score and grav SHALL hold their values in OVER and MENU until the next INIT.

Reset
REQ-019: resetn=0 SHALL asynchronously force the following: state MENU, frame counter 0, over counter 0, score 0, grav 0, overrun 0, and all request outputs 0.
REQ-020: Reset asserted mid-STEP or mid-DRAW SHALL drop the request in the same cycle, with no completion required from the peer.

Configuration
REQ-021: Macro JOSH_SEQ_SCORE_EN:
- Defined: score behaves per REQ-008, REQ-011 and REQ-018.
- Undefined: the score register is not built and score is tied to 8'd0; all other behaviour is unchanged.

Verification (FRAME_DIV=4, OVER_FRAMES=2, JOSH_SEQ_SCORE_EN defined)
REQ-022: go=1 for 3 cycles, then go=0 -> state sequence MENU_WAIT, INIT (clear_req=1 for one cycle, startgame=1), then WAIT_TICK.
REQ-023: Three frames, each with step_done and draw_done returned 1 cycle after the request, endgame=0 -> score=3, overrun=0, one step_req burst per tick.
REQ-024: Hold step_done=0 for 6 cycles -> overrun=1, state stays STEP, step_req stays 1; then step_done=1 with endgame=1 -> OVER, startgame=0.
REQ-025: In OVER, pulse go=1 -> ignored; after 2 ticks -> MENU, score holds its final value, overrun holds 1.
REQ-026: grav_sw toggled between ticks -> grav changes only on the tick edge; grav_sw toggled during STEP -> grav unchanged.
REQ-027: resetn=0 asserted mid-DRAW, between clock edges -> draw_req=0, state_dbg=0 and score=0 immediately, without a clock edge.
